// File: rtl/exec_writeback_stage_pkg.sv
// Shared definitions for the execute/writeback stage.
//   - opcode encodings produced by the decoder/ALU
//   - FSM state type
//   - bit positions inside the {N,Z,C,V} flags nibble
//   - small decode helpers
package exec_writeback_stage_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_MOVI = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1011;
  localparam logic [3:0] OP_LDR  = 4'b1101;
  localparam logic [3:0] OP_STR  = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_t;

  // Data-processing ops occupy the lower half of the opcode space (0000-0111).
  function automatic logic is_data_proc(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/exec_writeback_stage_mem_timeout_counter.sv
// Memory-access watchdog for the execute/writeback stage.
// Only instantiated when MEM_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart the count (asserted on the edge that enters MEM_WAIT)
//   wait_tick - one MEM_WAIT cycle elapsed without an ack
//   expired   - this wait_tick is the TIMEOUT_CYCLES-th one; abort the access
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  // Expiry is flagged on the tick that would bring the count to TIMEOUT_CYCLES,
  // so the request is held for exactly TIMEOUT_CYCLES wait cycles.
  assign expired = wait_tick && (count_reg == LAST_COUNT);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (wait_tick) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/exec_writeback_stage.sv
// Execute/writeback stage: retires one ALU result per handshake.
//   - data-processing ops (0000-0111): register writeback, optional flags update
//   - CMP: flags update only
//   - LDR/STR: blocking memory access over mem_req/mem_ack; LDR writes back
//     the load data one cycle after the ack
// Instructions with cond_met=0 are dropped. in_ready is low while an access
// is outstanding.
// Optional feature macro: MEM_TIMEOUT_EN -- aborts an access after
// TIMEOUT_CYCLES cycles without ack and raises the sticky err output.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   in_valid/in_ready           - upstream handshake
//   alu_out, store_data, opcode, cond_met, s_bit, flags_in, rd - instruction
//   mem_req/we/addr/wdata/rdata/ack - memory port
//   wb_en/wb_addr/wb_data       - register-file write port
//   flags_q                     - architectural flags {N,Z,C,V}
//   err                         - sticky memory-timeout error
module exec_writeback_stage
  import exec_writeback_stage_pkg::*;
#(
  parameter int REG_AW         = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  input  logic [3:0]        opcode,
  input  logic              cond_met,
  input  logic              s_bit,
  input  logic [3:0]        flags_in,
  input  logic [REG_AW-1:0] rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [31:0]       wb_data,
  output logic [3:0]        flags_q,
  output logic              err
);

  wb_state_t         state_reg, state_next;
  logic              mem_req_reg, mem_we_reg;
  logic [31:0]       mem_addr_reg, mem_wdata_reg;
  logic              wb_en_reg;
  logic [REG_AW-1:0] wb_addr_reg, ld_rd_reg;
  logic [31:0]       wb_data_reg;
  logic [3:0]        flags_reg;

  logic exec_go;    // accepted instruction whose condition passed
  logic mem_start;  // exec_go for LDR/STR
  logic mem_done;   // ack observed while the request is outstanding
  logic mem_abort;  // watchdog expiry (never when ack arrives the same cycle)

  // in_ready is forced low during reset so every output reads 0 under rst.
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign exec_go   = in_valid && (state_reg == IDLE) && cond_met;
  assign mem_start = exec_go && is_mem_op(opcode);
  assign mem_done  = (state_reg == MEM_WAIT) && mem_ack;

`ifdef MEM_TIMEOUT_EN
  logic timeout_expired;
  logic err_reg;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear    (mem_start),
    .wait_tick((state_reg == MEM_WAIT) && !mem_ack),
    .expired  (timeout_expired)
  );

  assign mem_abort = timeout_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (mem_abort) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign mem_abort = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (mem_start) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_done || mem_abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      wb_en_reg     <= 1'b0;
      wb_addr_reg   <= '0;
      wb_data_reg   <= '0;
      ld_rd_reg     <= '0;
      flags_reg     <= '0;
    end else begin
      wb_en_reg <= 1'b0;  // single-cycle strobe
      if (exec_go) begin
        if (is_data_proc(opcode)) begin
          wb_en_reg   <= 1'b1;
          wb_addr_reg <= rd;
          wb_data_reg <= alu_out;
          if (s_bit) begin
            flags_reg <= flags_in;
          end
        end else if (opcode == OP_CMP) begin
          flags_reg <= flags_in;
        end else if (opcode == OP_LDR) begin
          mem_req_reg  <= 1'b1;
          mem_we_reg   <= 1'b0;
          mem_addr_reg <= alu_out;
          ld_rd_reg    <= rd;
        end else if (opcode == OP_STR) begin
          mem_req_reg   <= 1'b1;
          mem_we_reg    <= 1'b1;
          mem_addr_reg  <= alu_out;
          mem_wdata_reg <= store_data;
        end
      end
      if (mem_done) begin
        mem_req_reg <= 1'b0;
        if (!mem_we_reg) begin
          wb_en_reg   <= 1'b1;
          wb_addr_reg <= ld_rd_reg;
          wb_data_reg <= mem_rdata;
        end
      end else if (mem_abort) begin
        mem_req_reg <= 1'b0;
      end
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign wb_en     = wb_en_reg;
  assign wb_addr   = wb_addr_reg;
  assign wb_data   = wb_data_reg;
  assign flags_q   = flags_reg;

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed bench for exec_writeback_stage. Inputs change 1 time unit after a
// rising edge; outputs are checked at the same point (away from the edge).
module tb_exec_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [3:0]  opcode;
  logic        cond_met;
  logic        s_bit;
  logic [3:0]  flags_in;
  logic [3:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  flags_q;
  logic        err;

  int vectors;
  int miscompares;

  exec_writeback_stage #(
    .REG_AW(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .store_data(store_data), .opcode(opcode),
    .cond_met(cond_met), .s_bit(s_bit), .flags_in(flags_in), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags_q(flags_q), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] r, input logic [31:0] a,
                       input logic [31:0] sd, input logic c, input logic s,
                       input logic [3:0] f);
    in_valid = 1'b1; opcode = op; rd = r; alu_out = a;
    store_data = sd; cond_met = c; s_bit = s; flags_in = f;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; alu_out = '0; store_data = '0; opcode = '0;
    cond_met = 1'b0; s_bit = 1'b0; flags_in = '0; rd = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_flags", {28'd0, flags_q}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: ADD rd=3 alu=7 S=1 flags=0100
    @(posedge clk); #1;
    issue(4'b0000, 4'd3, 32'h7, 32'h0, 1'b1, 1'b1, 4'b0100);
    tick(); in_valid = 1'b0;
    $display("tx ADD  rd=3 alu=7 -> wb_en=%0b wb_addr=%0d wb_data=%h flags=%b", wb_en, wb_addr, wb_data, flags_q);
    chk("add_wb_en", {31'd0, wb_en}, 32'd1);
    chk("add_wb_addr", {28'd0, wb_addr}, 32'd3);
    chk("add_wb_data", wb_data, 32'h7);
    chk("add_flags", {28'd0, flags_q}, 32'h4);

    // 2: CMP flags=1000 S=0, then SUB with cond_met=0
    issue(4'b1011, 4'd1, 32'h0, 32'h0, 1'b1, 1'b0, 4'b1000);
    tick();
    $display("tx CMP  flags_in=1000 -> flags=%b wb_en=%0b", flags_q, wb_en);
    chk("cmp_flags", {28'd0, flags_q}, 32'h8);
    chk("cmp_no_wb", {31'd0, wb_en}, 32'd0);
    chk("cmp_in_ready", {31'd0, in_ready}, 32'd1);
    issue(4'b0001, 4'd9, 32'h55, 32'h0, 1'b0, 1'b1, 4'b0111);
    tick(); in_valid = 1'b0;
    $display("tx SUB  cond=0 -> flags=%b wb_en=%0b", flags_q, wb_en);
    chk("sub_nc_no_wb", {31'd0, wb_en}, 32'd0);
    chk("sub_nc_flags", {28'd0, flags_q}, 32'h8);
    chk("sub_nc_wb_data_held", wb_data, 32'h7);
    chk("sub_nc_in_ready", {31'd0, in_ready}, 32'd1);

    // 3: LDR addr=0x100 rd=5, ack on the third mem_req cycle
    issue(4'b1101, 4'd5, 32'h100, 32'h0, 1'b1, 1'b0, 4'b0000);
    tick(); in_valid = 1'b0;
    chk("ldr_req", {31'd0, mem_req}, 32'd1);
    chk("ldr_we", {31'd0, mem_we}, 32'd0);
    chk("ldr_addr", mem_addr, 32'h100);
    chk("ldr_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ldr_wait_req", {31'd0, mem_req}, 32'd1);
      chk("ldr_wait_addr", mem_addr, 32'h100);
      chk("ldr_wait_in_ready", {31'd0, in_ready}, 32'd0);
      chk("ldr_wait_no_wb", {31'd0, wb_en}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); mem_ack = 1'b0; mem_rdata = 32'h0;
    $display("tx LDR  addr=100 rd=5 -> wb_en=%0b wb_addr=%0d wb_data=%h", wb_en, wb_addr, wb_data);
    chk("ldr_done_req", {31'd0, mem_req}, 32'd0);
    chk("ldr_wb_en", {31'd0, wb_en}, 32'd1);
    chk("ldr_wb_addr", {28'd0, wb_addr}, 32'd5);
    chk("ldr_wb_data", wb_data, 32'hDEADBEEF);
    chk("ldr_done_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ldr_wb_pulse", {31'd0, wb_en}, 32'd0);

    // 4: STR addr=0x200 data=0x55; upstream keeps in_valid with the next op (ADD rd=7)
    issue(4'b1110, 4'd0, 32'h200, 32'h55, 1'b1, 1'b0, 4'b0000);
    tick();
    issue(4'b0000, 4'd7, 32'h77, 32'h0, 1'b1, 1'b0, 4'b0011);
    chk("str_req", {31'd0, mem_req}, 32'd1);
    chk("str_we", {31'd0, mem_we}, 32'd1);
    chk("str_addr", mem_addr, 32'h200);
    chk("str_wdata", mem_wdata, 32'h55);
    chk("str_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("str_wait_req", {31'd0, mem_req}, 32'd1);
    chk("str_wait_no_accept", {31'd0, wb_en}, 32'd0);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    $display("tx STR  addr=200 data=55 -> mem_req=%0b wb_en=%0b in_ready=%0b", mem_req, wb_en, in_ready);
    chk("str_done_req", {31'd0, mem_req}, 32'd0);
    chk("str_no_wb", {31'd0, wb_en}, 32'd0);
    chk("str_done_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    $display("tx ADD  rd=7 alu=77 -> wb_en=%0b wb_addr=%0d wb_data=%h", wb_en, wb_addr, wb_data);
    chk("after_str_wb_en", {31'd0, wb_en}, 32'd1);
    chk("after_str_wb_addr", {28'd0, wb_addr}, 32'd7);
    chk("after_str_wb_data", wb_data, 32'h77);
    chk("after_str_flags", {28'd0, flags_q}, 32'h8);

    // 5: reset while in MEM_WAIT
    issue(4'b1101, 4'd2, 32'h300, 32'h0, 1'b1, 1'b0, 4'b0000);
    tick(); in_valid = 1'b0;
    chk("rstw_req_before", {31'd0, mem_req}, 32'd1);
    #1 rst = 1'b1;
    #1;
    $display("tx RST  mid-access -> mem_req=%0b flags=%b", mem_req, flags_q);
    chk("rstw_req_async", {31'd0, mem_req}, 32'd0);
    chk("rstw_flags", {28'd0, flags_q}, 32'd0);
    @(negedge clk); rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick(); mem_ack = 1'b0;
    chk("rstw_late_ack_no_wb", {31'd0, wb_en}, 32'd0);
    chk("rstw_late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("rstw_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rstw_late_ack_no_wb2", {31'd0, wb_en}, 32'd0);

    // 6: LDR that is never acked
    issue(4'b1101, 4'd4, 32'h400, 32'h0, 1'b1, 1'b0, 4'b0000);
    tick(); in_valid = 1'b0;
    chk("to_req", {31'd0, mem_req}, 32'd1);
    chk("to_err0", {31'd0, err}, 32'd0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_req", {31'd0, mem_req}, 32'd1);
      chk("to_wait_err", {31'd0, err}, 32'd0);
    end
    tick();
    $display("tx LDR  no ack -> mem_req=%0b err=%0b in_ready=%0b", mem_req, err, in_ready);
    chk("to_abort_req", {31'd0, mem_req}, 32'd0);
    chk("to_abort_err", {31'd0, err}, 32'd1);
    chk("to_abort_no_wb", {31'd0, wb_en}, 32'd0);
    chk("to_abort_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    chk("to_no_wb_later", {31'd0, wb_en}, 32'd0);
`else
    for (int i = 0; i < 10; i++) tick();
    $display("tx LDR  no ack x10 -> mem_req=%0b err=%0b", mem_req, err);
    chk("nto_still_req", {31'd0, mem_req}, 32'd1);
    chk("nto_err", {31'd0, err}, 32'd0);
    chk("nto_in_ready", {31'd0, in_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
    tick(); mem_ack = 1'b0;
    chk("nto_wb_en", {31'd0, wb_en}, 32'd1);
    chk("nto_wb_addr", {28'd0, wb_addr}, 32'd4);
    chk("nto_wb_data", wb_data, 32'hCAFE0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
